gnn_host_if: RTL and testbench
==============================

# gnn_host_if

Host-side load/unload controller for the two-layer, four-node GNN datapath. It accepts a serial stream of 5-bit operands (node features, then weights) over a valid/ready handshake and assembles them into a flat operand vector. It then issues a one-cycle start pulse to the datapath and waits for all eight output-ready flags. Finally it captures the eight OUT_W-bit results and streams them back out over a valid/ready/last handshake.

## Interface
- IN_W, 5, width of each feature/weight operand
- OUT_W, 21, width of each GNN result
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with GNN_HOST_TIMEOUT_EN)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  operand word valid
- s_ready  out  1  operand word accepted when s_valid & s_ready
- s_data  in  IN_W  signed operand word
- cfg_vec  out  40*IN_W  operand vector, word k at [k*IN_W +: IN_W]
- start  out  1  one-cycle launch pulse to datapath in_ready
- res_flat  in  8*OUT_W  results, slot k = node*2 + out at [k*OUT_W +: OUT_W]
- res_ready  in  8  per-slot ready flags, bit k matches slot k
- m_valid  out  1  result beat valid
- m_ready  in  1  result beat accepted when m_valid & m_ready
- m_data  out  OUT_W  result beat
- m_last  out  1  high on slot-7 beat
- busy  out  1  high unless in LOAD with word count 0
- err  out  1  sticky watchdog flag (tied 0 without GNN_HOST_TIMEOUT_EN)

## Operation
- Word order:
  - words 0–15 are features, x{f}_node{n} at index n*4+f.
  - words 16–39 are weights, w{i}{4+j} at index 16+4j+(i mod 4). Here j=0..3 uses i=0..3 (layer 1) and j=4,5 uses i=4..7 (w48..w78, w49..w79).
- States: LOAD, START, WAIT, DRAIN.
- LOAD:
  - s_ready=1.
  - Each handshake writes s_data into cfg_vec word cnt, and cnt increments.
  - The handshake at cnt=39 wraps cnt to 0 and moves to START.
- START: start=1 for exactly one cycle, then WAIT.
- WAIT:
  - s_ready=0; s_valid is ignored.
  - When res_ready==8'hFF, capture all eight slots of res_flat into holding registers and enter DRAIN with slot index 0.
- DRAIN:
  - m_valid=1, m_data=hold[idx], m_last=(idx==7).
  - Each handshake increments idx.
  - The handshake at idx=7 returns to LOAD.
  - Changes on res_ready/res_flat during DRAIN are ignored.
- cfg_vec holds its value from the last LOAD write until it is overwritten by the next load. It is not cleared after a run.
- No arithmetic is performed; all data is passed bit-exact.
- Reset (async, any state):
  - State goes to LOAD; cnt=0, idx=0.
  - cfg_vec, hold registers, start, m_valid, m_last, m_data, and err are all 0.
  - s_ready decodes to 1 (LOAD), but no transfer completes while rst_n is low.
  - A reset mid-WAIT or mid-DRAIN discards the run.

## Timing
- start is asserted in the cycle after the edge that accepted word 39.
- WAIT is entered on the following edge.
- If res_ready is all-high on WAIT edge C, m_valid is high, with slot 0 on m_data, in the cycle after C.
- Minimum DRAIN length is 8 cycles with m_ready held high.
- While m_ready=0, m_data and m_last stay stable.
- Back-to-back operation: the first word of the next load can be accepted in the cycle after the last DRAIN handshake.
- Minimum run time is 40 + 1 + 1 + datapath latency + 8 cycles.

## Configuration
- GNN_HOST_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without all-high res_ready, the block sets err=1, goes to LOAD, and drops cnt to 0.
  - If res_ready goes all-high in the same cycle as expiry, capture wins and err is not set.
  - err clears on the first accepted word of the next load.
- GNN_HOST_TIMEOUT_EN undefined: no counter; WAIT persists indefinitely; err is constant 0.

## Test plan
- **Load and launch:** load 40 words with value k mod 16 at index k. Require:
  - cfg_vec word k == k mod 16;
  - start high for exactly one cycle, the cycle after the word-39 handshake;
  - s_ready=0 afterwards.
- **Ready gating:** in WAIT, hold res_ready=8'h7F for 10 cycles, then 8'hFF, with slot k = k+100. Require:
  - no m_valid during the 8'h7F cycles;
  - m_valid=1 with m_data=100 in the cycle after 8'hFF.
- **Drain backpressure:** toggle m_ready 1/0 every cycle during DRAIN. Require:
  - eight beats 100..107 in order;
  - m_last only on 107;
  - data stable while stalled;
  - s_ready=1 after the last beat.
- **Input isolation:** pulse s_valid with data 5'h1F during WAIT and DRAIN. Require:
  - no cfg_vec change;
  - next load still starts at word 0.
- **Mid-run reset:** assert rst_n=0 mid-WAIT. Require, immediately:
  - start=0, m_valid=0, cfg_vec=0, busy=0;
  - a full load/run works normally after release.
- **Watchdog (GNN_HOST_TIMEOUT_EN defined):** hold res_ready=8'h00 for 64 WAIT cycles. Require:
  - err=1 and return to LOAD with s_ready=1;
  - err clears on the first new accepted word.
- **Watchdog (GNN_HOST_TIMEOUT_EN undefined):** same stimulus. Require the block to remain in WAIT and err=0.

Source files
------------

// File: rtl/gnn_host_if.sv
// Host-side load/unload controller for the 2-layer, 4-node GNN datapath.
// Optional WAIT watchdog enabled by defining GNN_HOST_TIMEOUT_EN.
module gnn_host_if #(
  parameter int unsigned IN_W           = 5,
  parameter int unsigned OUT_W          = 21,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_W-1:0]      s_data,
  output logic [40*IN_W-1:0]   cfg_vec,
  output logic                 start,
  input  logic [8*OUT_W-1:0]   res_flat,
  input  logic [7:0]           res_ready,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_W-1:0]     m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned N_WORDS = 40;
  localparam int unsigned N_SLOTS = 8;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [IDX_W-1:0]               idx;
  logic [N_WORDS-1:0][IN_W-1:0]   cfg_q;
  logic [N_SLOTS-1:0][OUT_W-1:0]  hold;

  assign cfg_vec = cfg_q;
  // Handshake/status flags are pure decodes of registered state
  assign s_ready = (state == S_LOAD);
  assign busy    = !((state == S_LOAD) && (cnt == '0));

`ifdef GNN_HOST_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LOAD;
      cnt     <= '0;
      idx     <= '0;
      cfg_q   <= '0;
      hold    <= '0;
      start   <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
`ifdef GNN_HOST_TIMEOUT_EN
      wd      <= '0;
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (s_valid) begin
            cfg_q[cnt] <= s_data;
`ifdef GNN_HOST_TIMEOUT_EN
            err <= 1'b0;
`endif
            if (cnt == CNT_W'(N_WORDS - 1)) begin
              cnt   <= '0;
              start <= 1'b1;
              state <= S_START;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_START: begin
          start <= 1'b0;
          state <= S_WAIT;
`ifdef GNN_HOST_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        S_WAIT: begin
          // Capture wins over a coincident watchdog expiry
          if (&res_ready) begin
            hold    <= res_flat;
            m_data  <= res_flat[OUT_W-1:0];
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            idx     <= '0;
            state   <= S_DRAIN;
          end
`ifdef GNN_HOST_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= S_LOAD;
          end else begin
            wd <= wd + WD_W'(1);
          end
`endif
        end
        S_DRAIN: begin
          if (m_ready) begin
            if (idx == IDX_W'(N_SLOTS - 1)) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              idx     <= '0;
              state   <= S_LOAD;
            end else begin
              idx    <= idx + IDX_W'(1);
              m_data <= hold[idx + IDX_W'(1)];
              m_last <= (idx == IDX_W'(N_SLOTS - 2));
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_gnn_host_if.sv
// Self-checking bench for gnn_host_if: vector table of full runs, result scoreboard,
// plus hand-written watchdog and mid-run reset sequences.
module tb_gnn_host_if;

  localparam int unsigned IN_W  = 5;
  localparam int unsigned OUT_W = 21;

  logic                clk;
  logic                rst_n;
  logic                s_valid;
  logic                s_ready;
  logic [IN_W-1:0]     s_data;
  logic [40*IN_W-1:0]  cfg_vec;
  logic                start;
  logic [8*OUT_W-1:0]  res_flat;
  logic [7:0]          res_ready;
  logic                m_valid;
  logic                m_ready;
  logic [OUT_W-1:0]    m_data;
  logic                m_last;
  logic                busy;
  logic                err;

  gnn_host_if dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_vec(cfg_vec), .start(start),
    .res_flat(res_flat), .res_ready(res_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    int         seed;
    logic [7:0] mask;
    int         cycles;
    int         base;
    int         step;
    bit         toggle;
    bit         poke;
  } vec_t;

  beat_t                   q[$];
  logic [39:0][IN_W-1:0]   exp_cfg;
  int                      n_cmp = 0;
  int                      n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] word_val(input int seed, input int k);
    if (seed == 0) return IN_W'(k % 16);
    return IN_W'(k * 13 * seed + seed);
  endfunction

  function automatic logic [OUT_W-1:0] res_val(input int base, input int step, input int k);
    return OUT_W'(base + step * k);
  endfunction

  // Scoreboard: every valid beat must match the queue head; pop on handshake
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (q.size() == 0) begin
        chk("beat_unexpected", m_valid, 1'b0);
      end else begin
        chk("beat_data", m_data, q[0].data);
        if (m_ready) begin
          chk("beat_last", m_last, q[0].last);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_load(input int seed);
    for (int k = 0; k < 40; k++) begin
      s_valid    = 1'b1;
      s_data     = word_val(seed, k);
      exp_cfg[k] = word_val(seed, k);
      @(negedge clk);
      if (k == 0) chk("load_busy_idle", busy, 1'b0);
      if (k == 1) begin
        chk("load_err_clear", err, 1'b0);
        chk("load_busy", busy, 1'b1);
      end
      if (k == 39) chk("load_s_ready", s_ready, 1'b1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("start_pulse", start, 1'b1);
    chk("start_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    chk("start_one_cycle", start, 1'b0);
    chk("cfg_loaded", cfg_vec, exp_cfg);
  endtask

  task automatic run_wait(input logic [7:0] mask, input int cycles, input int base,
                          input int step, input bit poke);
    logic [7:0][OUT_W-1:0] rv;
    for (int k = 0; k < 8; k++) rv[k] = res_val(base, step, k);
    res_flat = rv;
    for (int i = 0; i < cycles; i++) begin
      res_ready = mask;
      s_valid   = poke && (i == 0);
      s_data    = 5'h1F;
      @(negedge clk);
      chk("gate_no_valid", m_valid, 1'b0);
      @(posedge clk); #1;
    end
    s_valid   = 1'b0;
    res_ready = 8'hFF;
    for (int k = 0; k < 8; k++) q.push_back('{data: rv[k], last: (k == 7)});
    @(posedge clk); #1;
    res_ready = 8'h00;
    res_flat  = ~rv;
  endtask

  task automatic drain(input bit toggle, input bit poke);
    int cyc = 0;
    while (q.size() > 0 && cyc < 64) begin
      m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      s_valid = poke && (cyc == 0);
      s_data  = 5'h1F;
      @(negedge clk);
      if (cyc == 0) chk("first_beat_valid", m_valid, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    chk("drain_all_beats", q.size(), 0);
    q.delete();
    @(negedge clk);
    chk("post_drain_s_ready", s_ready, 1'b1);
    chk("post_drain_m_valid", m_valid, 1'b0);
    chk("cfg_isolated", cfg_vec, exp_cfg);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    do_load(v.seed);
    run_wait(v.mask, v.cycles, v.base, v.step, v.poke);
    drain(v.toggle, v.poke);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not reach its end within limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{seed: 0, mask: 8'h7F, cycles: 10, base: 100,        step: 1,        toggle: 1'b1, poke: 1'b1};
    vecs[1] = '{seed: 1, mask: 8'h00, cycles: 0,  base: 'h1FFFF8,   step: 1,        toggle: 1'b0, poke: 1'b0};
    vecs[2] = '{seed: 2, mask: 8'h80, cycles: 5,  base: 'h100000,   step: 'h0AAAA,  toggle: 1'b1, poke: 1'b1};
    vecs[3] = '{seed: 3, mask: 8'hFE, cycles: 1,  base: 0,          step: 0,        toggle: 1'b0, poke: 1'b1};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; res_flat = '0; res_ready = '0; m_ready = 1'b0;
    exp_cfg = '0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_start", start, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_cfg", cfg_vec, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Watchdog: res_ready held low through 64 WAIT cycles
    do_load(7);
    res_ready = 8'h00;
    repeat (63) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("wd_still_wait", s_ready, 1'b0);
    chk("wd_no_err_yet", err, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
`ifdef GNN_HOST_TIMEOUT_EN
    chk("wd_err_set", err, 1'b1);
    chk("wd_back_to_load", s_ready, 1'b1);
    chk("wd_no_valid", m_valid, 1'b0);
    @(posedge clk); #1;
    run_vec(vecs[1]);
`else
    chk("wd_err_zero", err, 1'b0);
    chk("wd_stays_wait", s_ready, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("wd_stays_wait_late", s_ready, 1'b0);
    chk("wd_no_valid", m_valid, 1'b0);
    @(posedge clk); #1;
    run_wait(8'h00, 0, 'h055555, 3, 1'b0);
    drain(1'b0, 1'b0);
`endif

    // Mid-run reset while in WAIT
    do_load(9);
    res_ready = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    exp_cfg = '0;
    chk("mid_rst_start", start, 1'b0);
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_cfg", cfg_vec, exp_cfg);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_s_ready", s_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
